// File: rtl/uc_alu_mc.sv
// Registered ALU control with multi-cycle mul/div sequencing.
// Decodes aluop/funct to a select code and stalls until mul/div latency expires.
module uc_alu_mc #(
    parameter int SEL_W   = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       aluop,
    input  logic [5:0]       funct,
    output logic [SEL_W-1:0] sel,
    output logic             start,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [0:0] {IDLE, WAIT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic               start_q, stall_q, done_q, ill_q;

    logic [3:0]         code_d;
    logic               ill_d, mul_d, div_d, multi_d;
    logic [CNT_W-1:0]   lat_m1_d;

    always_comb begin
        code_d = 4'b0000;
        ill_d  = 1'b0;
        case (aluop)
            3'b000: code_d = 4'b0000;
            3'b001: code_d = 4'b0001;
            3'b100: code_d = 4'b0100;
            3'b101: code_d = 4'b0101;
            3'b110: code_d = 4'b1000;
            3'b010: begin
                case (funct)
                    6'b100000: code_d = 4'b0000;
                    6'b100001: code_d = 4'b0001;
                    6'b100010: code_d = 4'b0010;
                    6'b100011: code_d = 4'b0011;
                    6'b100100: code_d = 4'b0100;
                    6'b100101: code_d = 4'b0101;
                    6'b100110: code_d = 4'b0110;
                    6'b100111: code_d = 4'b0111;
                    6'b101000: code_d = 4'b1000;
                    default:   ill_d  = 1'b1;
                endcase
            end
            default: ill_d = 1'b1;
        endcase
    end

    // Only the R-type path can yield the mul/div codes.
    assign mul_d    = !ill_d && (code_d == 4'b0010);
    assign div_d    = !ill_d && (code_d == 4'b0011);
    assign multi_d  = (mul_d && (MUL_LAT > 1)) || (div_d && (DIV_LAT > 1));
    assign lat_m1_d = mul_d ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        sel_q <= SEL_W'(code_d);
                        if (ill_d) begin
                            sel_q  <= '0;
                            ill_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (multi_d) begin
                            start_q <= 1'b1;
                            stall_q <= 1'b1;
                            cnt_q   <= lat_m1_d;
                            state_q <= WAIT;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel     = sel_q;
    assign start   = start_q;
    assign stall   = stall_q;
    assign busy    = stall_q;
    assign done    = done_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_uc_alu_mc.sv
// Bench for uc_alu_mc: directed scenarios plus random ops against a
// cycle-index reference model (accept cycle / done cycle bookkeeping).
module tb_uc_alu_mc;

    localparam int SEL_W   = 4;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic             clk = 1'b0;
    logic             rst, valid;
    logic [2:0]       aluop;
    logic [5:0]       funct;
    logic [SEL_W-1:0] sel;
    logic             start, stall, busy, done, illegal;

    int n_chk = 0;
    int n_err = 0;

    int cyc = 0;
    int acc = -100;
    int dn  = -100;
    int msel = 0;
    bit mill = 1'b0;

    uc_alu_mc #(
        .SEL_W(SEL_W), .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .aluop(aluop), .funct(funct), .sel(sel),
        .start(start), .stall(stall), .busy(busy),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Select code per the decode table; -1 means undecodable.
    function automatic int ref_code(input bit [2:0] a, input bit [5:0] f);
        if (a == 3'b010) begin
            if (f >= 6'd32 && f <= 6'd40) return int'(f) - 32;
            return -1;
        end
        case (a)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b100:  return 4;
            3'b101:  return 5;
            3'b110:  return 8;
            default: return -1;
        endcase
    endfunction

    task automatic step(input bit r, input bit v, input bit [2:0] a,
                        input bit [5:0] f);
        int p, c, code, lat;
        bit est, estart, edn;
        rst = r; valid = v; aluop = a; funct = f;
        @(posedge clk);
        #1;
        p = cyc;
        cyc++;
        c = cyc;
        if (r) begin
            acc = -100; dn = -100; msel = 0; mill = 1'b0;
        end else if (v && !(p > acc && p < dn)) begin
            code = ref_code(a, f);
            acc  = p;
            if (code < 0) begin
                msel = 0; mill = 1'b1; dn = p + 1;
            end else begin
                msel = code; mill = 1'b0;
                lat  = (code == 2) ? MUL_LAT : (code == 3) ? DIV_LAT : 1;
                dn   = p + lat;
            end
        end
        est    = (c > acc) && (c < dn);
        estart = (c == acc + 1) && (dn - acc > 1);
        edn    = (c == dn);
        chk("sel",     int'(sel),     msel);
        chk("start",   int'(start),   int'(estart));
        chk("stall",   int'(stall),   int'(est));
        chk("busy",    int'(busy),    int'(est));
        chk("done",    int'(done),    int'(edn));
        chk("illegal", int'(illegal), int'(edn && mill));
    endtask

    initial begin
        bit [5:0] f;
        rst = 1'b1; valid = 1'b0; aluop = '0; funct = '0;
        step(1, 0, 3'b000, 6'd0);
        step(1, 1, 3'b010, 6'b100011);
        // add then slt
        step(0, 1, 3'b010, 6'b100000);
        step(0, 1, 3'b010, 6'b101000);
        step(0, 0, 3'b000, 6'd0);
        // mul
        step(0, 1, 3'b010, 6'b100010);
        for (int i = 0; i < 4; i++) step(0, 0, 3'b000, 6'd0);
        // div with add held on valid, then toggling valid
        step(0, 1, 3'b010, 6'b100011);
        for (int i = 0; i < 33; i++)
            step(0, 1, 3'b010, 6'b100000);
        step(0, 0, 3'b000, 6'd0);
        step(0, 1, 3'b010, 6'b100011);
        for (int i = 0; i < 34; i++)
            step(0, i[0], 3'b010, 6'b100010);
        // illegal ops
        step(0, 1, 3'b010, 6'b111111);
        step(0, 1, 3'b011, 6'b100000);
        step(0, 1, 3'b111, 6'b100000);
        step(0, 0, 3'b000, 6'd0);
        // reset mid-divide, then add
        step(0, 1, 3'b010, 6'b100011);
        for (int i = 0; i < 21; i++) step(0, 0, 3'b000, 6'd0);
        step(1, 1, 3'b010, 6'b100011);
        step(0, 1, 3'b010, 6'b100000);
        step(0, 0, 3'b000, 6'd0);
        // aluop sweep with random funct
        step(0, 1, 3'b000, 6'($urandom));
        step(0, 1, 3'b001, 6'($urandom));
        step(0, 1, 3'b100, 6'($urandom));
        step(0, 1, 3'b101, 6'($urandom));
        step(0, 1, 3'b110, 6'($urandom));
        // random mix
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0)
                f = 6'(32 + $urandom_range(0, 8));
            else
                f = 6'($urandom);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0,
                 3'($urandom), f);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
